// File: rtl/demux_4by16_buf.sv
// ---------------------------------------------------------------------------
// demux_4by16_buf
//
// This block routes one input stream to one of four output channels. Each
// channel has a one-entry holding register and a valid/ready handshake. If one
// consumer stalls, words bound for the other channels are still accepted.
//
// Parameters
//   WIDTH      data width of the input word and of each output channel
//
// Ports
//   clk        system clock; all state updates happen on the rising edge
//   rst        synchronous, active-high reset
//   in_data    word to route
//   in_sel     destination channel index, 0..3
//   in_valid   the producer has a word on in_data/in_sel
//   in_bcast   (DEMUX_BCAST_EN only) load the word into all four channels
//   in_ready   the block accepts the word this cycle (combinational)
//   out_data   channel k occupies bits [k*WIDTH +: WIDTH] (registered)
//   out_valid  bit k is set while channel k holds a word (registered)
//   out_ready  bit k is set when consumer k takes the word this cycle
//   busy       OR of out_valid
//
// Optional build macro
//   DEMUX_BCAST_EN  adds the in_bcast input for loading all channels at once
//
// Channel state (full[k])
//   state | meaning
//   EMPTY | no word held; out_data slice k keeps its last value
//   FULL  | word held in data_q[k]; out_valid[k] is high until consumed
//
//   EMPTY -> FULL  on accept
//   FULL  -> EMPTY on drain without a simultaneous load
//   FULL  -> FULL  on stall, or on load and drain in the same cycle
// ---------------------------------------------------------------------------
module demux_4by16_buf #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
`ifdef DEMUX_BCAST_EN
    input  logic                 in_bcast,
`endif
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic                 busy
);

    localparam int NCH = 4;

    logic [NCH-1:0]   full;
    logic [WIDTH-1:0] data_q [NCH];

    logic [NCH-1:0]   ch_open;
    logic [NCH-1:0]   sel_onehot;
    logic [NCH-1:0]   load;
    logic             accept;

    // A channel can take a word if it is empty, or if its current word leaves
    // on this same edge. This gives one word per cycle per channel with no
    // bubble between words.
    always_comb begin
        ch_open    = ~full | out_ready;
        sel_onehot = 4'b0001 << in_sel;
        in_ready   = ch_open[in_sel];
        accept     = 1'b0;
        load       = '0;
`ifdef DEMUX_BCAST_EN
        if (in_bcast) begin
            in_ready = &ch_open;
            accept   = in_valid & in_ready;
            load     = {NCH{accept}};
        end else begin
            accept   = in_valid & in_ready;
            load     = accept ? sel_onehot : '0;
        end
`else
        accept = in_valid & in_ready;
        load   = accept ? sel_onehot : '0;
`endif
    end

    // If a load and a drain happen on the same channel in the same cycle, the
    // load wins. The flag stays set and the register takes the new word. The
    // old word counts as consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    full[k]   <= 1'b1;
                    data_q[k] <= in_data;
                end else if (out_ready[k]) begin
                    full[k]   <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign out_valid = full;
    assign busy      = |full;

endmodule

// File: tb/tb_demux_4by16_buf.sv
module tb_demux_4by16_buf;

    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
`ifdef DEMUX_BCAST_EN
    logic             in_bcast;
`endif
    logic             in_ready;
    logic [4*W-1:0]   out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] q3[$];

    demux_4by16_buf #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
`ifdef DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void push(int k, logic [W-1:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic void flush();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
    endfunction

    function automatic logic [W-1:0] slice(int k);
        return out_data[k*W +: W];
    endfunction

    // The monitor compares each word when it is consumed. A handshake is
    // visible at the falling edge before the rising edge that completes it.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    int sz;
                    logic [W-1:0] e;
                    case (k)
                        0: sz = q0.size();
                        1: sz = q1.size();
                        2: sz = q2.size();
                        default: sz = q3.size();
                    endcase
                    if (sz == 0) begin
                        n_checks++;
                        $display("FAIL ch%0d_unexpected: got %h expected no word", k, slice(k));
                    end else begin
                        case (k)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            2: e = q2.pop_front();
                            default: e = q3.pop_front();
                        endcase
                        check($sformatf("ch%0d_data", k), slice(k), e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset is held while a word is offered, so no channel may load.
        rst = 1'b1; in_valid = 1'b1; in_data = '1; in_sel = 2'd0; out_ready = 4'b0000;
`ifdef DEMUX_BCAST_EN
        in_bcast = 1'b0;
`endif
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        at_neg();
        check("rst_out_valid", W'(out_valid), 64'h0);
        check("rst_out_data_lo", out_data[127:0] == '0, 64'h1);
        check("rst_out_data_hi", out_data[255:128] == '0, 64'h1);
        check("rst_busy", W'(busy), 64'h0);

        // Unicast latency, then a five-cycle stall, then a drain.
        cyc();
        in_sel = 2'd2; in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1; push(2, in_data);
        at_neg();
        check("uni_in_ready", W'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("uni_out_valid", W'(out_valid), 64'h4);
        check("uni_slice2", slice(2), 64'h0123_4567_89AB_CDEF);
        check("uni_busy", W'(busy), 64'h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            at_neg();
            check($sformatf("stall%0d_slice2", i), slice(2), 64'h0123_4567_89AB_CDEF);
            check($sformatf("stall%0d_valid", i), W'(out_valid), 64'h4);
        end
        cyc();
        out_ready = 4'b0100;
        at_neg();
        cyc();
        out_ready = 4'b0000;
        at_neg();
        check("uni_drained", W'(out_valid), 64'h0);
        check("uni_hold_last", slice(2), 64'h0123_4567_89AB_CDEF);

        // Stall isolation: a full channel 1 must not block channel 3.
        cyc();
        in_sel = 2'd1; in_data = 64'h1111_0000_0000_0001; in_valid = 1'b1; push(1, in_data);
        cyc();
        in_data = 64'hDEAD_BEEF_0000_0003;
        at_neg();
        check("iso_ready_ch1", W'(in_ready), 64'h0);
        cyc();
        at_neg();
        check("iso_ch1_kept", slice(1), 64'h1111_0000_0000_0001);
        check("iso_ready_ch1_again", W'(in_ready), 64'h0);
        cyc();
        in_sel = 2'd3; push(3, in_data);
        at_neg();
        check("iso_ready_ch3", W'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("iso_valid", W'(out_valid), 64'hA);
        check("iso_slice3", slice(3), 64'hDEAD_BEEF_0000_0003);
        cyc();
        out_ready = 4'b1010;
        cyc();
        out_ready = 4'b1111;
        at_neg();
        check("iso_drained", W'(out_valid), 64'h0);
        check("idle_ready_nop", W'(busy), 64'h0);

        // Back-to-back streaming into channel 0 while its consumer is always ready.
        for (int i = 1; i <= 4; i++) begin
            cyc();
            in_sel = 2'd0; in_data = W'(i); in_valid = 1'b1; push(0, in_data);
            at_neg();
            check($sformatf("stream%0d_ready", i), W'(in_ready), 64'h1);
            if (i > 1) check($sformatf("stream%0d_valid0", i), W'(out_valid[0]), 64'h1);
        end
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("stream_last_valid0", W'(out_valid[0]), 64'h1);
        check("stream_last_slice0", slice(0), 64'h4);
        cyc();
        out_ready = 4'b0000;
        at_neg();
        check("stream_drained", W'(out_valid), 64'h0);

        // Reset in the middle of operation, with all four channels full and stalled.
        for (int k = 0; k < 4; k++) begin
            cyc();
            in_sel = 2'(k); in_data = 64'hA5A5_0000_0000_0000 | W'(k + 1); in_valid = 1'b1; push(k, in_data);
        end
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("mid_all_full", W'(out_valid), 64'hF);
        check("mid_slice1", slice(1), 64'hA5A5_0000_0000_0002);
        cyc();
        rst = 1'b1; flush();
        cyc();
        rst = 1'b0;
        at_neg();
        check("mid_rst_valid", W'(out_valid), 64'h0);
        check("mid_rst_data", W'(out_data == '0), 64'h1);
        check("mid_rst_busy", W'(busy), 64'h0);
        cyc();
        in_sel = 2'd0; in_data = 64'hCAFE_F00D_1234_5678; in_valid = 1'b1; push(0, in_data);
        at_neg();
        check("post_rst_ready", W'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("post_rst_valid", W'(out_valid), 64'h1);
        cyc();
        out_ready = 4'b0001;
        cyc();
        out_ready = 4'b0000;
        at_neg();
        check("post_rst_drained", W'(out_valid), 64'h0);

`ifdef DEMUX_BCAST_EN
        // Broadcast waits for every channel to be free, then loads all four.
        cyc();
        in_sel = 2'd2; in_data = 64'h2222_2222_2222_2222; in_valid = 1'b1; push(2, in_data);
        cyc();
        in_bcast = 1'b1; in_sel = 2'd0; in_data = 64'hB0B0_B0B0_1357_9BDF;
        at_neg();
        check("bc_blocked", W'(in_ready), 64'h0);
        cyc();
        out_ready = 4'b0100;
        for (int k = 0; k < 4; k++) push(k, in_data);
        at_neg();
        check("bc_ready", W'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
        at_neg();
        check("bc_valid", W'(out_valid), 64'hF);
        for (int k = 0; k < 4; k++) check($sformatf("bc_slice%0d", k), slice(k), 64'hB0B0_B0B0_1357_9BDF);
        cyc();
        out_ready = 4'b1111;
        cyc();
        out_ready = 4'b0000;
        at_neg();
        check("bc_drained", W'(out_valid), 64'h0);
`endif

        cyc();
        check("q0_empty", W'(q0.size()), 64'h0);
        check("q1_empty", W'(q1.size()), 64'h0);
        check("q2_empty", W'(q2.size()), 64'h0);
        check("q3_empty", W'(q3.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_4by16_buf.md
Name: demux_4by16_buf

Overview:
- Write-side counterpart of the 4-way datapath select: one input stream is routed to one of four output channels by a 2-bit select.
- Each output channel has a 1-entry holding register and a valid/ready handshake.
- Sits where a single producer (e.g. a result bus) feeds four consumers that may stall independently. A stall on one channel does not block words bound for the others.

Parameters:
- WIDTH, 64, data width in bits of the input word and of each output channel.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination channel index, 0..3.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block accepts the word this cycle. Combinational from in_sel, full[], out_ready[].
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]. Registered.
- out_valid  output  4  bit k set when channel k holds a word. Registered.
- out_ready  input  4  bit k set when consumer k takes the word this cycle.
- busy  output  1  OR of out_valid.

Behaviour:
- State per channel k: full[k] (1 bit) and data_q[k] (WIDTH bits). out_valid[k] = full[k]; out_data slice k = data_q[k].
- Reset (rst high at a clock edge): all full[k] = 0 and all data_q[k] = 0. Consequently out_valid = 0, out_data = 0, busy = 0 in the cycle after. Reset mid-transfer discards held words without handshake; in_valid is ignored during reset.
- Drain: when full[k] and out_ready[k], the channel empties at the clock edge, unless it is loaded in the same cycle.
- in_ready = !full[in_sel] | out_ready[in_sel]. Depends only on the selected channel; other channels' state has no effect.
- Accept: when in_valid & in_ready, then at the clock edge data_q[in_sel] <= in_data and full[in_sel] <= 1.
- Load and drain on the same channel in the same cycle: full stays 1, data_q takes the new word, and the old word counts as consumed. This gives 1 word/cycle per channel with no bubble.
- Latency: a word accepted in cycle N is visible on its channel with out_valid set in cycle N+1. There is no combinational path from in_data to out_data.
- out_valid[k] is held until consumed. data_q[k] is stable while full[k] and !out_ready[k].
- When a channel is empty, out_data slice k holds its last value (0 after reset). Consumers must qualify with out_valid.
- in_sel need not be stable while in_valid is high and in_ready is low. Each cycle is evaluated independently on the current in_sel.
- Ordering is preserved per channel. There is no ordering relation across channels.
- out_ready[k] while !full[k] has no effect.
- No internal FSM beyond the per-channel full flag. Each channel has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without a simultaneous load.
  - FULL → FULL on load+drain, or on stall.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast is high, in_sel is ignored and in_ready = AND over k of (!full[k] | out_ready[k]).
  - On accept, all four channels load in_data and set full.
  - When in_bcast is low, behaviour is identical to the undefined case.
- Undefined: port in_bcast does not exist; unicast behaviour only.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 and in_data=64'hFFFF_FFFF_FFFF_FFFF → out_valid=4'b0000, out_data all 0, busy=0, no channel loaded.
- Unicast latency: in_sel=2, in_data=64'h0123_4567_89AB_CDEF, in_valid=1 for 1 cycle, out_ready=4'b0000 → next cycle out_valid=4'b0100 and slice 2=64'h0123_4567_89AB_CDEF. Value holds for 5 stalled cycles. Raising out_ready[2] clears out_valid[2] the following cycle.
- Stall isolation: channel 1 full, out_ready[1]=0. in_sel=1 → in_ready=0 and data unchanged. Switch in_sel=3 with the same in_valid → in_ready=1 and channel 3 loads next cycle.
- Back-to-back streaming: out_ready=4'b1111 and words 1,2,3,4 sent to channel 0 on consecutive cycles → in_ready stays 1 and slice 0 shows 1,2,3,4 on consecutive cycles with out_valid[0] continuously high.
- Reset mid-operation: all four channels full and stalled, assert rst for 1 cycle → out_valid=0 and data 0 next cycle; a subsequent accept to channel 0 works normally.
- With DEMUX_BCAST_EN: channel 2 full and stalled, in_bcast=1 → in_ready=0. Release out_ready[2] → accept; next cycle out_valid=4'b1111 with all slices equal to in_data.
